symbol_measure_sched: RTL and testbench
=======================================

# symbol_measure_sched

Round-robin scheduler that shares one `symbol_measure` unit between `REQ_NUM` requesting channels. It accepts measurement requests, grants one channel at a time, pulses the measurement start, and waits for completion or timeout. It then returns the measured symbol length (or an error/timeout flag) to the granted channel. It sits between the per-channel link controllers and the single `symbol_measure` instance.

## Interface
Parameters:
- `REQ_NUM`, 4, number of requesting channels (2..8)
- `LEN_W`, 16, width of the measured symbol length
- `TO_CYC`, 1023, timeout in clk cycles counted in WAIT (1..2^16-1)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset; one clock domain, no other reset
- `req_vld`  in  REQ_NUM  per-channel request, level; held until acked
- `req_ack`  out  REQ_NUM  one-hot, one-cycle acceptance of the granted request
- `meas_start`  out  1  one-cycle start pulse to `symbol_measure`
- `meas_done`  in  1  one-cycle completion pulse from `symbol_measure`
- `meas_err`  in  1  measurement invalid; qualified by `meas_done`
- `meas_len`  in  LEN_W  measured length; qualified by `meas_done`
- `rsp_vld`  out  REQ_NUM  one-hot, one-cycle response pulse to the owning channel
- `rsp_len`  out  LEN_W  length, valid with `rsp_vld`; 0 on error/timeout
- `rsp_err`  out  1  `meas_err` seen, valid with `rsp_vld`
- `rsp_to`  out  1  timeout occurred, valid with `rsp_vld`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, START, WAIT, RSP.
- IDLE: if any `req_vld`, the round-robin arbiter picks a winner starting at `rr_ptr`. The block asserts `req_ack[win]`, latches `owner=win`, sets `rr_ptr=(win+1)%REQ_NUM`, and goes to START. With no request it stays in IDLE.
- START: assert `meas_start` for one cycle, clear the timeout counter, then go to WAIT.
- WAIT: the counter increments each cycle.
  - `meas_done=1`: latch `meas_len` and `meas_err`, go to RSP.
  - Otherwise, when the counter reaches `TO_CYC-1`: set the timeout flag, go to RSP.
  - `meas_done` in the same cycle as the timeout: done wins and no timeout is reported.
- RSP: assert `rsp_vld[owner]` with the latched `rsp_len`, `rsp_err`, `rsp_to`, then go to IDLE.
  - `rsp_len` is forced to 0 when `rsp_err` or `rsp_to` is set.
- `meas_done` outside WAIT is ignored.
- A requester dropping `req_vld` after ack has no effect. The transaction completes and still responds.
- Reset mid-operation: FSM to IDLE immediately. No response is issued for the aborted transaction. `rr_ptr` returns to 0.
- Reset values: all outputs 0; `rr_ptr=0`; `owner=0`; counter 0.
- Counter width is `$clog2(TO_CYC+1)` and it never wraps.

## Timing
- All outputs are registered.
- `req_vld` rising in IDLE produces `req_ack` in the same-cycle state. Sequence: ack at cycle N, `meas_start` at N+1, WAIT from N+2.
- `meas_done` at cycle M in WAIT produces `rsp_vld` at M+1 and IDLE at M+2. The earliest next ack is at M+2.
- Minimum turnaround is 4 cycles per request (IDLE, START, WAIT with done, RSP).
- Timeout response occurs exactly `TO_CYC+1` cycles after `meas_start`.
- Back-to-back requests from all channels are served in rotating order with no channel starved. The worst-case wait is `(REQ_NUM-1)` transactions.

## Structure
- Package `symbol_measure_pkg`: FSM state enum (`SM_IDLE`, `SM_START`, `SM_WAIT`, `SM_RSP`) and a default `TO_CYC` constant. The parameter defaults derive from `com_param.svh` where shared.
- Sub-module `rr_arb` (parameter `N`): combinational round-robin pick taking `req`, `ptr` and producing one-hot `gnt` and index `gnt_idx`. It is reusable by other shared-resource schedulers.
- The top level holds the FSM, counter, owner and latched response registers.

## Test plan
- Single request: `req_vld=4'b0010`, `meas_done` with `meas_len=16'h0123` 5 cycles after start. Expect `req_ack=0010`, one `meas_start`, then `rsp_vld=0010` with `rsp_len=0x0123`, `rsp_err=0`, `rsp_to=0`.
- All four requesting continuously with `meas_done` 3 cycles after each start. Expect grant order 0,1,2,3,0 and exactly one response per grant to the correct channel.
- No `meas_done` with `TO_CYC=10`. Expect `rsp_to=1` and `rsp_len=0` exactly 11 cycles after `meas_start`. Variant: `meas_done` on the timeout cycle gives `rsp_to=0` with the length reported.
- `meas_done` with `meas_err=1` and `meas_len=0x55`. Expect `rsp_err=1` and `rsp_len=0`. A stray `meas_done` in IDLE or START produces no response.
- Assert `rst_n=0` during WAIT. Expect all outputs 0 asynchronously and no `rsp_vld` after release. The next request from channel 2 is granted with `rr_ptr` restarting at 0.

Source files
------------

// File: rtl/symbol_measure_pkg.sv
// Shared types and defaults for the symbol_measure scheduler.
// Holds the FSM state encoding and parameter defaults.
package symbol_measure_pkg;

    typedef enum logic [1:0] {
        SM_IDLE  = 2'd0,
        SM_START = 2'd1,
        SM_WAIT  = 2'd2,
        SM_RSP   = 2'd3
    } sm_state_t;

    localparam int REQ_NUM_DEF = 4;
    localparam int LEN_W_DEF   = 16;
    localparam int TO_CYC_DEF  = 1023;

endpackage

// File: rtl/symbol_measure_sched_if.sv
// Bundle between the channel controllers, the scheduler and the symbol_measure unit.
// master = scheduler side, slave = channels plus measurement unit.
interface symbol_measure_sched_if #(
    parameter int REQ_NUM = 4,
    parameter int LEN_W   = 16
) ();
    logic [REQ_NUM-1:0] req_vld;
    logic [REQ_NUM-1:0] req_ack;
    logic               meas_start;
    logic               meas_done;
    logic               meas_err;
    logic [LEN_W-1:0]   meas_len;
    logic [REQ_NUM-1:0] rsp_vld;
    logic [LEN_W-1:0]   rsp_len;
    logic               rsp_err;
    logic               rsp_to;
    logic               busy;

    modport master (
        input  req_vld, meas_done, meas_err, meas_len,
        output req_ack, meas_start, rsp_vld, rsp_len, rsp_err, rsp_to, busy
    );

    modport slave (
        output req_vld, meas_done, meas_err, meas_len,
        input  req_ack, meas_start, rsp_vld, rsp_len, rsp_err, rsp_to, busy
    );
endinterface

// File: rtl/symbol_measure_sched_rr_arb.sv
// Round-robin pick: first requester at or after ptr wins; one-hot gnt plus index.
// Purely combinational, no backpressure; gnt is zero when req is zero.
module rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic        found;
    logic [IW:0] sum;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!found && req[sum[IW-1:0]]) begin
                found               = 1'b1;
                gnt[sum[IW-1:0]]    = 1'b1;
                gnt_idx             = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/symbol_measure_sched.sv
// Shares one symbol_measure unit among REQ_NUM channels: ack, start, wait done/timeout, respond.
// Min 4 cycles per request; requests simply wait (level req_vld) while busy.
module symbol_measure_sched
    import symbol_measure_pkg::*;
#(
    parameter int REQ_NUM = REQ_NUM_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TO_CYC  = TO_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    symbol_measure_sched_if.master bus
);

    localparam int IW = $clog2(REQ_NUM);
    localparam int CW = $clog2(TO_CYC + 1);

    sm_state_t          state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [REQ_NUM-1:0] req_ack_q, req_ack_d;
    logic               meas_start_q, meas_start_d;
    logic [REQ_NUM-1:0] rsp_vld_q, rsp_vld_d;
    logic [LEN_W-1:0]   rsp_len_q, rsp_len_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_to_q, rsp_to_d;
    logic               busy_q, busy_d;

    logic [REQ_NUM-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               timeout;

    rr_arb #(.N(REQ_NUM)) u_arb (
        .req     (bus.req_vld),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Counting starts the cycle after the start pulse, so the timeout
    // response lands exactly TO_CYC+1 cycles after meas_start.
    assign timeout = !meas_start_q && (cnt_q == CW'(TO_CYC - 1));

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        req_ack_d    = '0;
        meas_start_d = 1'b0;
        rsp_vld_d    = '0;
        rsp_len_d    = rsp_len_q;
        rsp_err_d    = rsp_err_q;
        rsp_to_d     = rsp_to_q;
        case (state_q)
            SM_IDLE: begin
                if (|bus.req_vld) begin
                    req_ack_d = gnt;
                    owner_d   = gnt_idx;
                    rr_ptr_d  = (gnt_idx == IW'(REQ_NUM - 1)) ? '0 : gnt_idx + IW'(1);
                    state_d   = SM_START;
                end
            end
            SM_START: begin
                meas_start_d = 1'b1;
                cnt_d        = '0;
                state_d      = SM_WAIT;
            end
            SM_WAIT: begin
                if (!meas_start_q && (cnt_q != CW'(TO_CYC))) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // done beats a coincident timeout
                if (bus.meas_done) begin
                    rsp_err_d = bus.meas_err;
                    rsp_to_d  = 1'b0;
                    rsp_len_d = bus.meas_err ? '0 : bus.meas_len;
                    rsp_vld_d = {{(REQ_NUM-1){1'b0}}, 1'b1} << owner_q;
                    state_d   = SM_RSP;
                end else if (timeout) begin
                    rsp_err_d = 1'b0;
                    rsp_to_d  = 1'b1;
                    rsp_len_d = '0;
                    rsp_vld_d = {{(REQ_NUM-1){1'b0}}, 1'b1} << owner_q;
                    state_d   = SM_RSP;
                end
            end
            SM_RSP: begin
                rsp_len_d = '0;
                rsp_err_d = 1'b0;
                rsp_to_d  = 1'b0;
                state_d   = SM_IDLE;
            end
            default: state_d = SM_IDLE;
        endcase
        busy_d = (state_d != SM_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SM_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            req_ack_q    <= '0;
            meas_start_q <= 1'b0;
            rsp_vld_q    <= '0;
            rsp_len_q    <= '0;
            rsp_err_q    <= 1'b0;
            rsp_to_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            req_ack_q    <= req_ack_d;
            meas_start_q <= meas_start_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_len_q    <= rsp_len_d;
            rsp_err_q    <= rsp_err_d;
            rsp_to_q     <= rsp_to_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.meas_start = meas_start_q;
    assign bus.rsp_vld    = rsp_vld_q;
    assign bus.rsp_len    = rsp_len_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_to     = rsp_to_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_symbol_measure_sched.sv
// Directed bench for symbol_measure_sched (REQ_NUM=4, LEN_W=16, TO_CYC=10).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_symbol_measure_sched;

    localparam int TO = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    symbol_measure_sched_if #(.REQ_NUM(4), .LEN_W(16)) bus ();

    symbol_measure_sched #(.REQ_NUM(4), .LEN_W(16), .TO_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.req_ack != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // dly >= 0: meas_done driven dly cycles after the start pulse; dly < 0: no done
    task automatic run_txn(input string tag, input int ch, input int dly,
                           input logic [15:0] len, input logic err,
                           input logic [15:0] exp_len, input logic exp_err, input logic exp_to,
                           input bit drop, input bit stray);
        bit ok;
        wait_ack(ok);
        chk({tag, "_ack_seen"}, 32'(ok), 32'd1);
        chk({tag, "_ack"}, 32'(bus.req_ack), 32'(1 << ch));
        if (drop) bus.req_vld[ch] = 1'b0;
        if (stray) begin
            bus.meas_done = 1'b1;
            bus.meas_len  = 16'h0777;
        end
        tick();
        bus.meas_done = 1'b0;
        chk({tag, "_start"}, 32'(bus.meas_start), 32'd1);
        if (stray) chk({tag, "_stray_start"}, 32'(bus.rsp_vld), 32'd0);
        if (dly >= 0) begin
            for (int i = 0; i < dly; i++) begin
                tick();
                if (i == 0) chk({tag, "_start_pulse"}, 32'(bus.meas_start), 32'd0);
            end
            bus.meas_done = 1'b1;
            bus.meas_len  = len;
            bus.meas_err  = err;
            tick();
            bus.meas_done = 1'b0;
            bus.meas_err  = 1'b0;
            bus.meas_len  = 16'hFFFF;
        end else begin
            bus.meas_len = 16'hFFFF;
            for (int i = 0; i < TO; i++) begin
                tick();
                if (i == 0) chk({tag, "_start_pulse"}, 32'(bus.meas_start), 32'd0);
            end
            chk({tag, "_no_early_rsp"}, 32'(bus.rsp_vld), 32'd0);
            tick();
        end
        chk({tag, "_rsp_vld"}, 32'(bus.rsp_vld), 32'(1 << ch));
        chk({tag, "_rsp_len"}, 32'(bus.rsp_len), 32'(exp_len));
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, "_rsp_to"},  32'(bus.rsp_to),  32'(exp_to));
        tick();
        chk({tag, "_rsp_once"}, 32'(bus.rsp_vld), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ok;
        logic seen;
        bus.req_vld   = '0;
        bus.meas_done = 1'b0;
        bus.meas_err  = 1'b0;
        bus.meas_len  = '0;

        // reset state
        tick(); tick();
        chk("rst_outs", 32'({bus.req_ack, bus.meas_start, bus.rsp_vld, bus.rsp_len,
                             bus.rsp_err, bus.rsp_to, bus.busy}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // single request, requester drops after ack
        bus.req_vld = 4'b0010;
        run_txn("single", 1, 5, 16'h0123, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("single_idle", 32'(bus.busy), 32'd0);

        // all four requesting, rr pointer fresh from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_txn("rr", k % 4, 3, 16'h0100 + 16'(k), 1'b0, 16'h0100 + 16'(k),
                    1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.req_vld = 4'b0000;

        // timeout, then done on the timeout cycle
        bus.req_vld = 4'b1000;
        run_txn("tmo", 3, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.req_vld = 4'b0001;
        run_txn("tmo_done", 0, TO, 16'h0ABC, 1'b0, 16'h0ABC, 1'b0, 1'b0, 1'b1, 1'b0);

        // measurement error
        bus.req_vld = 4'b0100;
        run_txn("err", 2, 2, 16'h0055, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // stray done in IDLE
        bus.meas_done = 1'b1;
        bus.meas_len  = 16'h0777;
        tick();
        bus.meas_done = 1'b0;
        chk("stray_idle_rsp", 32'(bus.rsp_vld), 32'd0);
        chk("stray_idle_busy", 32'(bus.busy), 32'd0);

        // stray done in START (ptr now 3 -> channel 1 wins)
        bus.req_vld = 4'b0010;
        run_txn("stray_st", 1, 4, 16'h0042, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b1, 1'b1);

        // reset during WAIT
        bus.req_vld = 4'b0010;
        wait_ack(ok);
        chk("mid_ack", 32'(bus.req_ack), 32'b0010);
        bus.req_vld = 4'b0000;
        tick(); tick(); tick();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({bus.req_ack, bus.meas_start, bus.rsp_vld, bus.rsp_len,
                                 bus.rsp_err, bus.rsp_to, bus.busy}), 32'd0);
        bus.meas_done = 1'b1;
        bus.meas_len  = 16'h0999;
        tick();
        bus.meas_done = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | (|bus.rsp_vld) | bus.busy;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);

        // rr_ptr back at 0: channel 1 beats channel 2, then channel 2
        bus.req_vld = 4'b0110;
        run_txn("post_rst_c1", 1, 1, 16'h0011, 1'b0, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);
        run_txn("post_rst_c2", 2, 1, 16'h0022, 1'b0, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
